// File: rtl/sw_conditioner.sv
// sw_conditioner: input conditioner between the raw board switches and the picoMips core.
//
// Every SW_raw bit is synchronised through SYNC_STAGES flops. The handshake bit (SW_raw[8])
// is debounced by a four-state FSM that accepts a level change only after DEBOUNCE_CYCLES
// consecutive identical synchronised samples. The data bits (SW_raw[7:0]) track the
// synchroniser while the debounced handshake is low and are frozen from the edge the
// handshake is accepted high until the first edge after it is accepted low again.
//
// Ports:
//   Clock        in   1  system clock, rising edge
//   nReset       in   1  asynchronous active-low reset
//   SW_raw       in   9  raw switches; [8] = handshake, [7:0] = data
//   SW_out       out  9  conditioned switches; [8] = debounced handshake, [7:0] = data
//   hs_rise      out  1  one-cycle pulse coincident with SW_out[8] 0->1
//   hs_fall      out  1  one-cycle pulse coincident with SW_out[8] 1->0
//   glitch_count out  8  saturating count of aborted handshake transitions
module sw_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  localparam int unsigned CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic [8:0] SW_raw,
  output logic [8:0] SW_out,
  output logic       hs_rise,
  output logic       hs_fall,
  output logic [7:0] glitch_count
);

  // Elaboration-time guard on parameter ranges.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("sw_conditioner: SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("sw_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Synchroniser: the only reader of SW_raw.
  // ---------------------------------------------------------------------------
  logic [8:0] sync_q [SYNC_STAGES];

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= SW_raw;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  logic       sync_hs;
  logic [7:0] sync_data;

  assign sync_hs   = sync_q[SYNC_STAGES-1][8];
  assign sync_data = sync_q[SYNC_STAGES-1][7:0];

  // ---------------------------------------------------------------------------
  // Debounce FSM and data freeze.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    StLo,
    StPendHi,
    StHi,
    StPendLo
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hs_q, hs_d;
  logic [7:0]       data_q, data_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [7:0]       glitch_q, glitch_d;
  logic             glitch_inc;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hs_d       = hs_q;
    data_d     = data_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;

    unique case (state_q)
      StLo: begin
        data_d = sync_data;
        if (sync_hs) begin
          state_d = StPendHi;
          cnt_d   = CntOne;
        end
      end

      StPendHi: begin
        // Loading here also covers the capture on the edge that enters HI.
        data_d = sync_data;
        if (!sync_hs) begin
          state_d    = StLo;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d = StHi;
          cnt_d   = '0;
          hs_d    = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StHi: begin
        if (!sync_hs) begin
          state_d = StPendLo;
          cnt_d   = CntOne;
        end
      end

      StPendLo: begin
        // Data stays frozen; tracking resumes only once the FSM sits in LO.
        if (sync_hs) begin
          state_d    = StHi;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d = StLo;
          cnt_d   = '0;
          hs_d    = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      default: begin
        state_d = StLo;
        cnt_d   = '0;
        hs_d    = 1'b0;
      end
    endcase
  end

  // Saturating: stays at 255 until reset.
  always_comb begin
    glitch_d = glitch_q;
    if (glitch_inc && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= StLo;
      cnt_q    <= '0;
      hs_q     <= 1'b0;
      data_q   <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hs_q     <= hs_d;
      data_q   <= data_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign SW_out       = {hs_q, data_q};
  assign hs_rise      = rise_q;
  assign hs_fall      = fall_q;
  assign glitch_count = glitch_q;

endmodule

// File: tb/tb_sw_conditioner.sv
// tb_sw_conditioner: directed bench for sw_conditioner.
//
// A run-length model (delay line + "samples seen against the stable level") predicts every
// output and is compared each cycle; literal checks at hand-computed edges pin the model.
module tb_sw_conditioner;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned Debounce   = 16;

  logic       Clock;
  logic       nReset;
  logic [8:0] SW_raw;
  logic [8:0] SW_out;
  logic       hs_rise;
  logic       hs_fall;
  logic [7:0] glitch_count;

  int n_cmp;
  int n_err;

  sw_conditioner #(
    .SYNC_STAGES    (SyncStages),
    .DEBOUNCE_CYCLES(Debounce)
  ) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .SW_raw      (SW_raw),
    .SW_out      (SW_out),
    .hs_rise     (hs_rise),
    .hs_fall     (hs_fall),
    .glitch_count(glitch_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: raw samples delayed SyncStages edges, then a run-length debounce:
  // a level is accepted after Debounce consecutive samples differing from the
  // stable level; a matching sample that cuts a run short is a glitch.
  // Data follows the delayed sample whenever the stable level is low.
  // ---------------------------------------------------------------------------
  logic [8:0] m_pipe [SyncStages];
  logic       m_lvl, m_lvl_n;
  int         m_run, m_run_n;
  int         m_glitch, m_glitch_n;
  logic [7:0] m_data, m_data_n;
  logic       m_rise, m_rise_n;
  logic       m_fall, m_fall_n;
  logic [8:0] m_s;

  always_comb begin
    m_s        = m_pipe[SyncStages-1];
    m_lvl_n    = m_lvl;
    m_run_n    = m_run;
    m_glitch_n = m_glitch;
    m_data_n   = m_lvl ? m_data : m_s[7:0];
    m_rise_n   = 1'b0;
    m_fall_n   = 1'b0;
    if (m_s[8] != m_lvl) begin
      m_run_n = m_run + 1;
      if (m_run_n == int'(Debounce)) begin
        m_lvl_n  = m_s[8];
        m_run_n  = 0;
        m_rise_n = m_s[8];
        m_fall_n = !m_s[8];
      end
    end else begin
      if (m_run > 0 && m_glitch < 255) m_glitch_n = m_glitch + 1;
      m_run_n = 0;
    end
  end

  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < int'(SyncStages); i++) m_pipe[i] <= '0;
      m_lvl    <= 1'b0;
      m_run    <= 0;
      m_glitch <= 0;
      m_data   <= '0;
      m_rise   <= 1'b0;
      m_fall   <= 1'b0;
    end else begin
      m_pipe[0] <= SW_raw;
      for (int i = 1; i < int'(SyncStages); i++) m_pipe[i] <= m_pipe[i-1];
      m_lvl    <= m_lvl_n;
      m_run    <= m_run_n;
      m_glitch <= m_glitch_n;
      m_data   <= m_data_n;
      m_rise   <= m_rise_n;
      m_fall   <= m_fall_n;
    end
  end

  // Cycle-by-cycle compare, sampled 2 time units after each rising edge.
  initial begin
    forever begin
      @(posedge Clock);
      #2;
      check("model_sw_out", 32'(SW_out), 32'({m_lvl, m_data}));
      check("model_hs_rise", 32'(hs_rise), 32'(m_rise));
      check("model_hs_fall", 32'(hs_fall), 32'(m_fall));
      check("model_glitch", 32'(glitch_count), 32'(m_glitch));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  logic fall_seen;

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    nReset = 1'b0;
    SW_raw = '0;
    step(3);
    check("reset_sw_out", 32'(SW_out), 32'h0);
    check("reset_glitch", 32'(glitch_count), 32'h0);
    nReset = 1'b1;

    // 1: clean press with data A5.
    SW_raw = 9'h0A5;
    step(5);
    SW_raw[8] = 1'b1;
    step(17);
    check("press_edge17_hs", 32'(SW_out[8]), 32'h0);
    step(1);
    check("press_edge18_out", 32'(SW_out), 32'h1A5);
    check("press_rise_pulse", 32'(hs_rise), 32'h1);
    step(1);
    check("press_rise_gone", 32'(hs_rise), 32'h0);
    check("press_glitch", 32'(glitch_count), 32'h0);

    // 2: data frozen while high, tracking resumes after the fall.
    SW_raw[7:0] = 8'h3C;
    step(6);
    check("freeze_data", 32'(SW_out[7:0]), 32'hA5);
    SW_raw[8] = 1'b0;
    step(17);
    check("release_edge17", 32'(SW_out), 32'h1A5);
    step(1);
    check("release_edge18", 32'(SW_out), 32'h0A5);
    check("release_fall", 32'(hs_fall), 32'h1);
    step(1);
    check("release_track", 32'(SW_out), 32'h03C);
    check("release_fall_gone", 32'(hs_fall), 32'h0);

    // 3: bounce 5 high / 3 low, four times, then stable high.
    step(4);
    for (int i = 0; i < 4; i++) begin
      SW_raw[8] = 1'b1;
      step(5);
      SW_raw[8] = 1'b0;
      step(3);
    end
    SW_raw[8] = 1'b1;
    step(17);
    check("bounce_edge17", 32'(SW_out[8]), 32'h0);
    step(1);
    check("bounce_edge18", 32'(SW_out[8]), 32'h1);
    check("bounce_glitch", 32'(glitch_count), 32'd4);

    // 4: one-cycle low while high.
    step(3);
    SW_raw[8] = 1'b0;
    step(1);
    SW_raw[8] = 1'b1;
    fall_seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step(1);
      if (hs_fall) fall_seen = 1'b1;
    end
    check("hi_glitch_nofall", 32'(fall_seen), 32'h0);
    check("hi_glitch_hs", 32'(SW_out[8]), 32'h1);
    check("hi_glitch_count", 32'(glitch_count), 32'd5);

    // 5: reset in PEND_HI at cnt=10.
    SW_raw[8] = 1'b0;
    step(20);
    check("pre_reset_hs", 32'(SW_out[8]), 32'h0);
    SW_raw[8] = 1'b1;
    step(12);
    nReset = 1'b0;
    #1;
    check("midreset_out", 32'(SW_out), 32'h0);
    check("midreset_glitch", 32'(glitch_count), 32'h0);
    check("midreset_rise", 32'(hs_rise), 32'h0);
    step(2);
    nReset = 1'b1;
    step(17);
    check("after_reset_edge17", 32'(SW_out[8]), 32'h0);
    step(1);
    check("after_reset_edge18", 32'(SW_out), 32'h13C);
    check("after_reset_rise", 32'(hs_rise), 32'h1);

    // 6: 300 aborted presses saturate the glitch counter.
    SW_raw[8] = 1'b0;
    step(20);
    for (int i = 0; i < 300; i++) begin
      SW_raw[8] = 1'b1;
      step(3);
      SW_raw[8] = 1'b0;
      step(3);
    end
    step(5);
    check("sat_count", 32'(glitch_count), 32'd255);
    SW_raw[8] = 1'b1;
    step(3);
    SW_raw[8] = 1'b0;
    step(5);
    check("sat_hold", 32'(glitch_count), 32'd255);
    check("sat_hs_low", 32'(SW_out[8]), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
